// File: rtl/cache_req_extractor_if.sv
// cache_req_extractor_if: AXI AR/AW address channel bundle feeding the request extractor
interface cache_req_extractor_if #(
  parameter int ADDR_WIDTH = 64,
  parameter int ID_WIDTH   = 16
);
  logic [ID_WIDTH-1:0]   arid_i;
  logic [ADDR_WIDTH-1:0] araddr_i;
  logic                  arvalid_i;
  logic                  arready_o;
  logic [ID_WIDTH-1:0]   awid_i;
  logic [ADDR_WIDTH-1:0] awaddr_i;
  logic                  awvalid_i;
  logic                  awready_o;
  modport master (
    output arid_i, araddr_i, arvalid_i, awid_i, awaddr_i, awvalid_i,
    input  arready_o, awready_o
  );
  modport slave (
    input  arid_i, araddr_i, arvalid_i, awid_i, awaddr_i, awvalid_i,
    output arready_o, awready_o
  );
endinterface

// File: rtl/cache_req_extractor.sv
// cache_req_extractor: arbitrates AR/AW, extracts set index, pushes one descriptor per accept under a credit limit
module cache_req_extractor #(
  parameter int ADDR_WIDTH      = 64,
  parameter int ID_WIDTH        = 16,
  parameter int INDEX_BIT_SIZE  = 4,
  parameter int INDEX_LSB       = 6,
  parameter int FIFO_WIDTH      = 128,
  parameter int ARB_MODE        = 0,
  parameter int MAX_OUTSTANDING = 8,
  localparam int CW             = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  cache_req_extractor_if.slave      axi,
  output logic [INDEX_BIT_SIZE-1:0] index_o,
  input  logic                      fifo_afull_i,
  output logic                      fifo_write_en_o,
  output logic [FIFO_WIDTH-1:0]     fifo_data_o,
  input  logic                      resp_done_i,
  output logic [CW-1:0]             outstanding_o
);
  typedef enum logic {GNT_R = 1'b0, GNT_W = 1'b1} grant_t;
  grant_t                last_grant, next_grant, grant;
  logic                  can_accept, accept, done_eff;
  logic [ID_WIDTH-1:0]   acc_id;
  logic [ADDR_WIDTH-1:0] acc_addr;
  logic [FIFO_WIDTH-1:0] desc;
  // grant selection: a lone valid wins; ties resolved by the configured policy
  always_comb begin
    grant = axi.awvalid_i ? GNT_W : GNT_R;
    if (axi.arvalid_i && axi.awvalid_i)
      grant = ARB_MODE == 1 ? GNT_R :
              ARB_MODE == 2 ? GNT_W :
              (last_grant == GNT_W ? GNT_R : GNT_W);
  end
  // handshake: readies held low in reset, on almost-full and when credits run out
  always_comb begin
    can_accept    = rst_n && !fifo_afull_i && (outstanding_o < CW'(MAX_OUTSTANDING));
    axi.arready_o = can_accept && grant == GNT_R && axi.arvalid_i;
    axi.awready_o = can_accept && grant == GNT_W && axi.awvalid_i;
    accept        = axi.arready_o || axi.awready_o;
    done_eff      = resp_done_i && outstanding_o != '0;
    next_grant    = accept ? grant : last_grant;
  end
  // descriptor assembly from the granted channel: {addr, id, is_write}, zero padded
  always_comb begin
    acc_id   = grant == GNT_W ? axi.awid_i : axi.arid_i;
    acc_addr = grant == GNT_W ? axi.awaddr_i : axi.araddr_i;
    desc     = FIFO_WIDTH'({acc_addr, acc_id, grant == GNT_W});
  end
  // arbitration history; reset to write so the first tie goes to read
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) last_grant <= GNT_W;
    else        last_grant <= next_grant;
  // push register: one-cycle strobe, data and index held until the next accept
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fifo_write_en_o <= 1'b0;
      fifo_data_o     <= '0;
      index_o         <= '0;
    end else begin
      fifo_write_en_o <= accept;
      if (accept) begin
        fifo_data_o <= desc;
        index_o     <= acc_addr[INDEX_LSB +: INDEX_BIT_SIZE];
      end
    end
  end
  // credit counter: accept adds, retire removes, retire at zero is ignored
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)                    outstanding_o <= '0;
    else if (accept && !done_eff)  outstanding_o <= outstanding_o + 1'b1;
    else if (!accept && done_eff)  outstanding_o <= outstanding_o - 1'b1;
endmodule

// File: tb/tb_cache_req_extractor.sv
// tb_cache_req_extractor: three policy/credit variants driven in lockstep against a behavioural model
module tb_cache_req_extractor;
  logic clk = 1'b0, rst_n = 1'b0;
  logic arv = 1'b0, awv = 1'b0, afull = 1'b0, done = 1'b0;
  logic [15:0] arid = '0, awid = '0;
  logic [63:0] araddr = '0, awaddr = '0;
  logic [2:0] ar_rdy, aw_rdy, we_dut, ar_seen, aw_seen;
  logic [127:0] d_dut [3];
  logic [3:0] idx_dut [3];
  logic [3:0] o0, o1;
  logic [1:0] o2;
  logic [3:0] o_dut [3];
  int total = 0, bad = 0;
  int MODE [3] = '{0, 1, 2};
  int MAXO [3] = '{8, 8, 2};
  bit m_lg [3];
  bit m_we [3];
  int m_cnt [3];
  logic [127:0] m_data [3];
  logic [3:0] m_idx [3];
  always #5 clk = ~clk;
  cache_req_extractor_if b0 (), b1 (), b2 ();
  assign b0.arid_i = arid;   assign b0.araddr_i = araddr; assign b0.arvalid_i = arv;
  assign b0.awid_i = awid;   assign b0.awaddr_i = awaddr; assign b0.awvalid_i = awv;
  assign b1.arid_i = arid;   assign b1.araddr_i = araddr; assign b1.arvalid_i = arv;
  assign b1.awid_i = awid;   assign b1.awaddr_i = awaddr; assign b1.awvalid_i = awv;
  assign b2.arid_i = arid;   assign b2.araddr_i = araddr; assign b2.arvalid_i = arv;
  assign b2.awid_i = awid;   assign b2.awaddr_i = awaddr; assign b2.awvalid_i = awv;
  assign ar_rdy = {b2.arready_o, b1.arready_o, b0.arready_o};
  assign aw_rdy = {b2.awready_o, b1.awready_o, b0.awready_o};
  always_comb o_dut = '{o0, o1, {2'b00, o2}};
  cache_req_extractor #(.ARB_MODE(0), .MAX_OUTSTANDING(8)) u0 (
    .clk(clk), .rst_n(rst_n), .axi(b0), .index_o(idx_dut[0]), .fifo_afull_i(afull),
    .fifo_write_en_o(we_dut[0]), .fifo_data_o(d_dut[0]), .resp_done_i(done), .outstanding_o(o0));
  cache_req_extractor #(.ARB_MODE(1), .MAX_OUTSTANDING(8)) u1 (
    .clk(clk), .rst_n(rst_n), .axi(b1), .index_o(idx_dut[1]), .fifo_afull_i(afull),
    .fifo_write_en_o(we_dut[1]), .fifo_data_o(d_dut[1]), .resp_done_i(done), .outstanding_o(o1));
  cache_req_extractor #(.ARB_MODE(2), .MAX_OUTSTANDING(2)) u2 (
    .clk(clk), .rst_n(rst_n), .axi(b2), .index_o(idx_dut[2]), .fifo_afull_i(afull),
    .fifo_write_en_o(we_dut[2]), .fifo_data_o(d_dut[2]), .resp_done_i(done), .outstanding_o(o2));
  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h @%0t", name, act, exp, $time);
    end
  endtask
  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      m_lg[i] = 1'b1; m_we[i] = 1'b0; m_cnt[i] = 0; m_data[i] = '0; m_idx[i] = '0;
    end
  endtask
  task automatic check_regs();
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("we[%0d]", i), we_dut[i], m_we[i]);
      chk($sformatf("data[%0d]", i), d_dut[i], m_data[i]);
      chk($sformatf("index[%0d]", i), idx_dut[i], m_idx[i]);
      chk($sformatf("outstanding[%0d]", i), o_dut[i], 128'(m_cnt[i]));
    end
  endtask
  task automatic step();
    check_regs();
    #1;
    ar_seen = ar_rdy;
    aw_seen = aw_rdy;
    for (int i = 0; i < 3; i++) begin
      bit gw, can, er, ew, acc, de;
      gw = (arv && awv) ? (MODE[i] == 0 ? !m_lg[i] : MODE[i] == 2) : awv;
      can = !afull && m_cnt[i] < MAXO[i];
      er = can && arv && !gw;
      ew = can && awv && gw;
      chk($sformatf("arready[%0d]", i), ar_rdy[i], er);
      chk($sformatf("awready[%0d]", i), aw_rdy[i], ew);
      acc = er || ew;
      de = done && m_cnt[i] > 0;
      m_we[i] = acc;
      if (acc) begin
        m_lg[i] = gw;
        m_data[i] = gw ? {47'b0, awaddr, awid, 1'b1} : {47'b0, araddr, arid, 1'b0};
        m_idx[i] = gw ? awaddr[9:6] : araddr[9:6];
      end
      m_cnt[i] += (acc ? 1 : 0) - (de ? 1 : 0);
    end
    @(negedge clk);
  endtask
  task automatic drive(input logic a, input logic w, input logic f, input logic d);
    arv = a; awv = w; afull = f; done = d;
    arid = 16'($urandom); awid = 16'($urandom);
    araddr = {$urandom, $urandom}; awaddr = {$urandom, $urandom};
  endtask
  task automatic drain();
    drive(0, 0, 0, 1);
    repeat (9) step();
    for (int i = 0; i < 3; i++) chk($sformatf("drained[%0d]", i), o_dut[i], 0);
  endtask
  initial begin
    model_reset();
    arv = 1'b1; awv = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("reset_arready", ar_rdy, 0);
    chk("reset_awready", aw_rdy, 0);
    check_regs();
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      drive(1, 1, 0, 0);
      step();
      chk("tie_rr_bit0", d_dut[0][0], k % 2);
      chk("tie_rd_prio_bit0", d_dut[1][0], 0);
      chk("tie_wr_prio_we", we_dut[2], k < 2);
    end
    drain();
    drive(1, 0, 0, 0);
    araddr = 64'h0000_0000_0000_01C0; arid = 16'h5;
    step();
    chk("single_arready", ar_seen[0], 1);
    chk("single_we", we_dut[0], 1);
    chk("single_bit0", d_dut[0][0], 0);
    chk("single_id", d_dut[0][16:1], 16'h5);
    chk("single_index", idx_dut[0], 4'h7);
    drain();
    for (int k = 0; k < 3; k++) begin
      drive(1, 0, 0, 0);
      step();
    end
    chk("credit_full_arready", ar_seen[2], 0);
    chk("credit_full_cnt", o_dut[2], 2);
    drive(1, 0, 0, 1);
    step();
    chk("credit_retire_cnt", o_dut[2], 1);
    drive(1, 0, 0, 0);
    step();
    chk("credit_reuse_arready", ar_seen[2], 1);
    chk("credit_reuse_cnt", o_dut[2], 2);
    drive(0, 0, 0, 1);
    step();
    drive(1, 0, 0, 1);
    step();
    chk("credit_both_arready", ar_seen[2], 1);
    chk("credit_both_cnt", o_dut[2], 1);
    drain();
    drive(1, 1, 1, 0);
    step();
    chk("afull_ready", {ar_seen, aw_seen}, 0);
    chk("afull_nopush", we_dut, 0);
    drive(1, 1, 0, 0);
    step();
    chk("afull_release_push", we_dut, 3'b111);
    for (int k = 0; k < 600; k++) begin
      drive(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0),
            1'($urandom_range(0, 4) == 0), 1'($urandom_range(0, 2) == 0));
      step();
    end
    drain();
    drive(1, 0, 0, 0);
    step();
    chk("pre_reset_push", we_dut, 3'b111);
    #2 rst_n = 1'b0;
    #1;
    chk("midreset_we", we_dut, 0);
    chk("midreset_cnt", {o_dut[0], o_dut[1], o_dut[2]}, 0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    drive(1, 1, 0, 0);
    step();
    chk("post_reset_tie_read", d_dut[0][0], 0);
    drive(0, 0, 0, 0);
    step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
